host_link: RTL and testbench
============================

# host_link

Host-side bridge for the multi-core processor top level. Collects a byte stream from an external source (UART RX or testbench), packs it into 16-bit words in a local load buffer, then replays it as the gap-free one-word-per-clock burst the processor's load port requires. Captures the processor's result stream into a local result buffer and drains it back out as bytes under a valid/ready handshake. This block is the opposite end of the processor's `data_write_start`/`data_write_done` and `output_write_start`/`output_write_done` protocol.

## Interface
- `LOAD_WORDS`, 1024: words assembled and burst per job; power of two, ≥ 2.
- `OUT_WORDS`, 1024: result words captured per job; power of two, ≥ 2.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx_valid` input 1: `rx_byte` valid this cycle; no backpressure, so the byte must be accepted.
- `rx_byte` input 8: host byte; the low byte of each word arrives first.
- `com_data_in` output 16: word driven to the processor load port.
- `data_write_start` output 1: one-cycle pulse that opens the load burst.
- `data_write_done` output 1: high only in the cycle carrying the last load word.
- `com_data_out` input 16: processor result word.
- `output_write_start` input 1: processor result stream active.
- `output_write_done` input 1: processor result stream finished.
- `tx_valid` output 1: `tx_byte` holds a valid byte.
- `tx_ready` input 1: downstream accepts `tx_byte` this cycle.
- `tx_byte` output 8: result byte; the low byte of each word is sent first.
- `link_state` output 3: current FSM state encoding.
- `rx_overrun` output 1: sticky flag; set when a byte arrives outside FILL.

## Operation
- FSM states and encodings:
  - FILL (0): assembles byte pairs into words and writes them to the load buffer at `wr_ptr`.
  - START (1): asserts `data_write_start`.
  - GAP (2): one idle cycle.
  - BURST (3): drives `com_data_in` with `buf[rd_ptr]` and increments `rd_ptr` every cycle.
  - WAIT (4): waits for the result stream.
  - CAPTURE (5): stores one result word per cycle.
  - DRAIN (6): sends result bytes to the host.
- Transitions:
  - FILL→START when word `LOAD_WORDS-1` has been written.
  - START→GAP→BURST unconditionally.
  - BURST→WAIT in the cycle after `rd_ptr==LOAD_WORDS-1`.
  - WAIT→CAPTURE when `output_write_start==1` and `output_write_done==0`.
  - CAPTURE→DRAIN when `output_write_done==1` or after `OUT_WORDS` words.
  - DRAIN→FILL after the last byte handshake.
- Word packing: `word = {second_byte, first_byte}`. A byte-phase toggle resets on entry to FILL.
- BURST timing:
  - Word 0 appears exactly 2 cycles after the `data_write_start` cycle.
  - Word k appears at start+2+k.
  - `data_write_done=1` together with word `LOAD_WORDS-1`, then 0.
- CAPTURE:
  - Writes `com_data_out` at `cap_ptr` on every cycle with start=1 and done=0.
  - Words beyond `OUT_WORDS` are dropped.
  - If `output_write_done` arrives early, only `cap_ptr` words are drained.
- DRAIN:
  - Emits 2×N bytes, where N = number of captured words.
  - `tx_byte` and `tx_valid` are held stable until `tx_ready`.
  - The next byte is presented the cycle after the handshake.
- Bytes received in any state other than FILL are discarded and set `rx_overrun`. The flag clears only on reset.
- Pointers are `$clog2(depth)` bits wide and wrap naturally. The end condition is detected by compare, never by overflow.

## Timing
- Reset values:
  - `link_state`=FILL.
  - All pointers and the byte phase = 0.
  - `com_data_in`=16'h0000.
  - `data_write_start`=0, `data_write_done`=0.
  - `tx_valid`=0, `tx_byte`=8'h00.
  - `rx_overrun`=0.
  - Buffer contents are undefined.
- Latency:
  - The last byte in FILL is followed by START on the next cycle.
  - WAIT→CAPTURE entry captures the same cycle's `com_data_out`.
- `com_data_in` is registered and holds its last value outside BURST.
- Simultaneous `output_write_start` and `output_write_done` in WAIT: no capture; go to DRAIN with N=0, then FILL.
- Reset assertion mid-burst or mid-drain:
  - Outputs return to reset values immediately (asynchronously).
  - A partial job is abandoned.

## Configuration
- `HOST_LINK_CHECKSUM_EN`:
  - Defined: DRAIN appends one extra word after the data. That word is the 16-bit wrap-around sum of all captured words, sent low byte first, for 2×N+2 bytes total.
  - Undefined: no checksum logic, exactly 2×N bytes.

## Test plan
- Reset mid-BURST with `LOAD_WORDS=4` → all outputs at reset values immediately; the next job starts cleanly from FILL.
- Feed 8 bytes 01 00 02 00 03 00 04 00 with `LOAD_WORDS=4` → start pulse, then `com_data_in` = 0001, 0002, 0003, 0004 at start+2..+5, done high only with 0004.
- Result stream 16'hA000..16'hA003 (`OUT_WORDS=4`) with `tx_ready` always 1 → `tx_byte` 00 A0 01 A0 02 A0 03 A0, back to FILL.
- `tx_ready` toggling 1,0,0,1 → each byte stays stable while held; no byte lost or duplicated.
- `output_write_done` after 2 words → 4 bytes drained; with `HOST_LINK_CHECKSUM_EN`, words 0x0001 and 0xFFFF give checksum 0x0000, for 6 bytes total.
- Byte arriving during WAIT → `rx_overrun`=1 and stays set; the byte is ignored.

Source files
------------

// File: rtl/host_link.sv
// rtl/host_link.sv - host-side byte bridge feeding the processor load port and draining its results
//
// Purpose:
//   Packs an incoming byte stream into 16-bit words in a local load buffer.
//   Replays the buffer as a gap-free one-word-per-clock burst to the processor.
//   Captures the processor result stream and drains it back out as bytes
//   under a valid/ready handshake.
//
// Optional feature (macro HOST_LINK_CHECKSUM_EN):
//   When defined, the drain appends the 16-bit wrap-around sum of the
//   captured words, sent low byte first.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   rx_valid, rx_byte   host byte input, low byte of each word first, no backpressure
//   com_data_in         registered word driven to the processor load port
//   data_write_start    one-cycle pulse opening the load burst
//   data_write_done     high with the last load word only
//   com_data_out        processor result word
//   output_write_start  processor result stream active
//   output_write_done   processor result stream finished
//   tx_valid, tx_ready  result byte handshake
//   tx_byte             result byte, low byte of each word first
//   link_state          current FSM state encoding
//   rx_overrun          sticky: a byte arrived outside FILL
module host_link #(
  parameter int LOAD_WORDS = 1024,
  parameter int OUT_WORDS  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic [15:0] com_data_in,
  output logic        data_write_start,
  output logic        data_write_done,
  input  logic [15:0] com_data_out,
  input  logic        output_write_start,
  input  logic        output_write_done,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_byte,
  output logic [2:0]  link_state,
  output logic        rx_overrun
);

  localparam int LAW = $clog2(LOAD_WORDS);
  localparam int OAW = $clog2(OUT_WORDS);

  localparam logic [2:0] S_FILL    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_GAP     = 3'd2;
  localparam logic [2:0] S_BURST   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;
  localparam logic [2:0] S_DRAIN   = 3'd6;

  localparam logic [LAW-1:0] LAST_LOAD = LAW'(LOAD_WORDS - 1);
  localparam logic [OAW-1:0] LAST_OUT  = OAW'(OUT_WORDS - 1);
  localparam logic [LAW-1:0] L_ONE     = LAW'(1);
  localparam logic [OAW-1:0] O_ONE     = OAW'(1);
  localparam logic [OAW:0]   W_ONE     = (OAW + 1)'(1);

  logic [2:0]     state_q, state_d;
  logic [LAW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LAW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OAW-1:0] cap_ptr_q, cap_ptr_d;
  logic           cap_full_q, cap_full_d;
  logic           phase_q, phase_d;
  logic [7:0]     lo_q, lo_d;
  logic [OAW:0]   dr_w_q, dr_w_d;
  logic           dr_h_q, dr_h_d;
  logic [15:0]    com_data_in_q, com_data_in_d;
  logic           dws_q, dws_d;
  logic           dwd_q, dwd_d;
  logic           tx_valid_q, tx_valid_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic           ovr_q, ovr_d;
`ifdef HOST_LINK_CHECKSUM_EN
  logic [15:0]    sum_q, sum_d;
`endif

  logic [15:0] load_mem [LOAD_WORDS];
  logic [15:0] out_mem  [OUT_WORDS];

  logic           load_we;
  logic [15:0]    load_wdata;
  logic           out_we;
  logic [LAW-1:0] rd_next;
  logic [OAW:0]   n_words;
  logic [OAW:0]   total_w;
  logic [15:0]    cur_word;

  // A full buffer wraps cap_ptr back to 0, so the flag supplies the extra count bit.
  assign n_words = {cap_full_q, cap_ptr_q};
  assign rd_next = rd_ptr_q + L_ONE;

`ifdef HOST_LINK_CHECKSUM_EN
  assign total_w  = n_words + W_ONE;
  assign cur_word = (dr_w_q < n_words) ? out_mem[dr_w_q[OAW-1:0]] : sum_q;
`else
  assign total_w  = n_words;
  assign cur_word = out_mem[dr_w_q[OAW-1:0]];
`endif

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cap_ptr_d     = cap_ptr_q;
    cap_full_d    = cap_full_q;
    phase_d       = phase_q;
    lo_d          = lo_q;
    dr_w_d        = dr_w_q;
    dr_h_d        = dr_h_q;
    com_data_in_d = com_data_in_q;
    dws_d         = 1'b0;
    dwd_d         = 1'b0;
    tx_valid_d    = tx_valid_q;
    tx_byte_d     = tx_byte_q;
    ovr_d         = ovr_q | (rx_valid && (state_q != S_FILL));
    load_we       = 1'b0;
    load_wdata    = {rx_byte, lo_q};
    out_we        = ((state_q == S_WAIT) || (state_q == S_CAPTURE)) &&
                    output_write_start && !output_write_done && !cap_full_q;
`ifdef HOST_LINK_CHECKSUM_EN
    sum_d         = out_we ? (sum_q + com_data_out) : sum_q;
`endif

    case (state_q)
      S_FILL: begin
        if (rx_valid) begin
          if (!phase_q) begin
            lo_d    = rx_byte;
            phase_d = 1'b1;
          end else begin
            load_we  = 1'b1;
            phase_d  = 1'b0;
            wr_ptr_d = wr_ptr_q + L_ONE;
            if (wr_ptr_q == LAST_LOAD) begin
              state_d = S_START;
              dws_d   = 1'b1;
            end
          end
        end
      end
      S_START: state_d = S_GAP;
      S_GAP: begin
        // The output register is loaded one cycle ahead, so word 0 is
        // fetched here and appears with the first BURST cycle.
        state_d       = S_BURST;
        com_data_in_d = load_mem[rd_ptr_q];
      end
      S_BURST: begin
        // rd_ptr_q indexes the word currently on com_data_in.
        rd_ptr_d = rd_next;
        if (rd_ptr_q == LAST_LOAD) begin
          state_d = S_WAIT;
        end else begin
          com_data_in_d = load_mem[rd_next];
          dwd_d         = (rd_next == LAST_LOAD);
        end
      end
      S_WAIT: begin
        if (output_write_start) begin
          if (output_write_done) begin
            state_d = S_DRAIN;
          end else begin
            state_d   = S_CAPTURE;
            cap_ptr_d = cap_ptr_q + O_ONE;
          end
        end
      end
      S_CAPTURE: begin
        if (output_write_done) begin
          state_d = S_DRAIN;
        end else if (out_we) begin
          cap_ptr_d = cap_ptr_q + O_ONE;
          if (cap_ptr_q == LAST_OUT) begin
            cap_full_d = 1'b1;
            state_d    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Load a new byte when the register is empty or just handed off.
        if (!tx_valid_q || tx_ready) begin
          if (dr_w_q < total_w) begin
            tx_valid_d = 1'b1;
            tx_byte_d  = dr_h_q ? cur_word[15:8] : cur_word[7:0];
            dr_h_d     = ~dr_h_q;
            if (dr_h_q) dr_w_d = dr_w_q + W_ONE;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = S_FILL;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cap_ptr_d  = '0;
            cap_full_d = 1'b0;
            phase_d    = 1'b0;
            dr_w_d     = '0;
            dr_h_d     = 1'b0;
`ifdef HOST_LINK_CHECKSUM_EN
            sum_d      = 16'h0000;
`endif
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FILL;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cap_ptr_q     <= '0;
      cap_full_q    <= 1'b0;
      phase_q       <= 1'b0;
      lo_q          <= 8'h00;
      dr_w_q        <= '0;
      dr_h_q        <= 1'b0;
      com_data_in_q <= 16'h0000;
      dws_q         <= 1'b0;
      dwd_q         <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_byte_q     <= 8'h00;
      ovr_q         <= 1'b0;
`ifdef HOST_LINK_CHECKSUM_EN
      sum_q         <= 16'h0000;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cap_ptr_q     <= cap_ptr_d;
      cap_full_q    <= cap_full_d;
      phase_q       <= phase_d;
      lo_q          <= lo_d;
      dr_w_q        <= dr_w_d;
      dr_h_q        <= dr_h_d;
      com_data_in_q <= com_data_in_d;
      dws_q         <= dws_d;
      dwd_q         <= dwd_d;
      tx_valid_q    <= tx_valid_d;
      tx_byte_q     <= tx_byte_d;
      ovr_q         <= ovr_d;
`ifdef HOST_LINK_CHECKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

  // Buffer storage carries no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (load_we) load_mem[wr_ptr_q] <= load_wdata;
    if (out_we) out_mem[cap_ptr_q] <= com_data_out;
  end

  assign com_data_in      = com_data_in_q;
  assign data_write_start = dws_q;
  assign data_write_done  = dwd_q;
  assign tx_valid         = tx_valid_q;
  assign tx_byte          = tx_byte_q;
  assign link_state       = state_q;
  assign rx_overrun       = ovr_q;

endmodule

// File: tb/tb_host_link.sv
// tb/tb_host_link.sv - scoreboard bench for host_link with 4-word buffers
module tb_host_link;
  localparam int LW = 4;
  localparam int OW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic [15:0] com_data_in;
  logic        data_write_start;
  logic        data_write_done;
  logic [15:0] com_data_out = 16'h0000;
  logic        output_write_start = 1'b0;
  logic        output_write_done = 1'b0;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_byte;
  logic [2:0]  link_state;
  logic        rx_overrun;

  always #5 clk = ~clk;

  host_link #(.LOAD_WORDS(LW), .OUT_WORDS(OW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .com_data_in(com_data_in), .data_write_start(data_write_start),
    .data_write_done(data_write_done), .com_data_out(com_data_out),
    .output_write_start(output_write_start), .output_write_done(output_write_done),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte),
    .link_state(link_state), .rx_overrun(rx_overrun)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_load [$];
  logic [7:0]  exp_tx [$];
  bit toggle_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load-port monitor: word k must sit on com_data_in at start+2+k.
  initial begin
    int bcnt;
    logic [15:0] w;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt = 0;
      end else if (bcnt > 0) begin
        bcnt++;
        if (bcnt == 2) begin
          chk("start_pulse_width", {31'd0, data_write_start}, 0);
        end else if (bcnt >= 3 && bcnt <= LW + 2) begin
          if (exp_load.size() == 0) begin
            checks++; errors++;
            $display("FAIL load_unexpected: got %0h expected none", com_data_in);
          end else begin
            w = exp_load.pop_front();
            chk("load_word", {16'd0, com_data_in}, {16'd0, w});
          end
          chk("load_done", {31'd0, data_write_done}, (bcnt == LW + 2) ? 1 : 0);
        end else if (bcnt == LW + 3) begin
          chk("load_done_after", {31'd0, data_write_done}, 0);
          bcnt = 0;
        end
      end else if (data_write_start) begin
        bcnt = 1;
      end
    end
  end

  // Result-byte monitor: pops on each handshake, and checks held bytes stay put.
  initial begin
    bit hold;
    logic [7:0] prev;
    logic [7:0] e;
    hold = 1'b0;
    prev = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("tx_hold_valid", {31'd0, tx_valid}, 1);
          chk("tx_hold_byte", {24'd0, tx_byte}, {24'd0, prev});
        end
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected: got %0h expected none", tx_byte);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_byte", {24'd0, tx_byte}, {24'd0, e});
          end
        end
        hold = tx_valid && !tx_ready;
        prev = tx_byte;
      end
    end
  end

  // tx_ready driver: constant 1, or the repeating 1,0,0,1 pattern.
  initial begin
    logic pat [4];
    int pi;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    pi = 0;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_mode) begin
        tx_ready = pat[pi];
        pi = (pi + 1) % 4;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (link_state !== s && n < budget) begin
      tick();
      n++;
    end
    chk(name, {29'd0, link_state}, {29'd0, s});
  endtask

  task automatic send_load(input logic [15:0] w [4]);
    for (int i = 0; i < LW; i++) exp_load.push_back(w[i]);
    for (int i = 0; i < LW; i++) begin
      rx_valid = 1'b1;
      rx_byte = w[i][7:0];
      tick();
      rx_byte = w[i][15:8];
      tick();
    end
    rx_valid = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic expect_words(input logic [15:0] w [4], input int n);
    logic [15:0] s;
    s = 16'h0000;
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(w[i][7:0]);
      exp_tx.push_back(w[i][15:8]);
      s = s + w[i];
    end
`ifdef HOST_LINK_CHECKSUM_EN
    exp_tx.push_back(s[7:0]);
    exp_tx.push_back(s[15:8]);
`endif
  endtask

  // n words with start=1/done=0, then one cycle of start=1/done=1.
  task automatic result_stream(input logic [15:0] w [4], input int n);
    for (int i = 0; i < n; i++) begin
      output_write_start = 1'b1;
      output_write_done = 1'b0;
      com_data_out = w[i];
      tick();
    end
    output_write_start = 1'b1;
    output_write_done = 1'b1;
    com_data_out = 16'hDEAD;
    tick();
    output_write_start = 1'b0;
    output_write_done = 1'b0;
    com_data_out = 16'h0000;
  endtask

  task automatic run_job(input string tag, input logic [15:0] lw [4],
                         input logic [15:0] rw [4], input int n);
    send_load(lw);
    wait_state(3'd4, 20, {tag, "_reach_wait"});
    chk({tag, "_load_left"}, exp_load.size(), 0);
    expect_words(rw, n);
    result_stream(rw, n);
    wait_state(3'd0, 200, {tag, "_back_to_fill"});
    chk({tag, "_tx_left"}, exp_tx.size(), 0);
  endtask

  initial begin
    logic [15:0] la [4], lb [4], lc [4], ra [4], rb [4], rc [4], rz [4];
    la = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    lb = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    lc = '{16'h00FF, 16'h8001, 16'h7E7E, 16'hC3A5};
    ra = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    rb = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    rc = '{16'h0001, 16'hFFFF, 16'h5555, 16'h6666};
    rz = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};

    #3;
    chk("rst_state", {29'd0, link_state}, 0);
    chk("rst_com_data_in", {16'd0, com_data_in}, 0);
    chk("rst_dws", {31'd0, data_write_start}, 0);
    chk("rst_dwd", {31'd0, data_write_done}, 0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 0);
    chk("rst_tx_byte", {24'd0, tx_byte}, 0);
    chk("rst_overrun", {31'd0, rx_overrun}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    run_job("job_a", la, ra, 4);
    toggle_mode = 1'b1;
    run_job("job_toggle", lc, rb, 4);
    toggle_mode = 1'b0;
    tick();
    run_job("job_early", lb, rc, 2);
    run_job("job_empty", la, rz, 0);
    chk("overrun_clean", {31'd0, rx_overrun}, 0);

    // Reset in the middle of a burst.
    send_load(lb);
    wait_state(3'd3, 20, "reach_burst");
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", {29'd0, link_state}, 0);
    chk("mid_rst_com_data_in", {16'd0, com_data_in}, 0);
    chk("mid_rst_dws", {31'd0, data_write_start}, 0);
    chk("mid_rst_dwd", {31'd0, data_write_done}, 0);
    chk("mid_rst_tx_valid", {31'd0, tx_valid}, 0);
    exp_load.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // Clean job after reset, with a stray byte during WAIT.
    send_load(la);
    wait_state(3'd4, 20, "post_rst_wait");
    chk("post_rst_load_left", exp_load.size(), 0);
    rx_valid = 1'b1;
    rx_byte = 8'h55;
    tick();
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    chk("overrun_set", {31'd0, rx_overrun}, 1);
    chk("overrun_state", {29'd0, link_state}, 4);
    expect_words(ra, 4);
    result_stream(ra, 4);
    wait_state(3'd0, 200, "post_rst_fill");
    chk("post_rst_tx_left", exp_tx.size(), 0);
    chk("overrun_sticky", {31'd0, rx_overrun}, 1);

    // Next job still packs from the low byte: the stray byte was dropped.
    run_job("job_after_ovr", lb, rb, 4);
    chk("overrun_sticky_end", {31'd0, rx_overrun}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
